dm_port_arbiter: RTL

//  Shares the single-port data memory (mem: clk, data_in, data_out, we_DM, addres_dm) between two

---
 rtl/dm_arb_pkg.sv | 6 +
 rtl/rr_arb2.sv | 19 +
 rtl/dm_port_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared FSM states and port indices for the data-memory port arbiter
package dm_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    localparam logic P_CPU = 1'b0;
    localparam logic P_DBG = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant; on a tie the port that did not win last time gets it
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt,
    output logic       any
);
    logic last_grant;
    assign any = |req;
    assign gnt = &req ? ~last_grant : req[P_DBG];
    always_ff @(posedge clk) begin
        if (rst) last_grant <= P_DBG;
        else if (en && any) last_grant <= gnt;
    end
endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port data memory between the CPU and debug/DMA ports
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 4,
    parameter int RD_LAT        = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p0_valid,
    output logic                     p0_ready,
    input  logic                     p0_we,
    input  logic [ADDRESS_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]    p0_wdata,
    output logic                     p0_rvalid,
    output logic [DATA_WIDTH-1:0]    p0_rdata,
    input  logic                     p1_valid,
    output logic                     p1_ready,
    input  logic                     p1_we,
    input  logic [ADDRESS_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]    p1_wdata,
    output logic                     p1_rvalid,
    output logic [DATA_WIDTH-1:0]    p1_rdata,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     busy
);
    localparam int CW = 2;
    state_t                   state;
    logic                     gnt, any, gport, lat_we, mem_we_q;
    logic [CW-1:0]            cnt;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata, rdata_q;

    rr_arb2 u_rr (
        .clk (clk),
        .rst (rst),
        .req ({p1_valid, p0_valid}),
        .en  (state == IDLE),
        .gnt (gnt),
        .any (any)
    );

    assign p0_ready  = !rst && state == IDLE && any && gnt == P_CPU;
    assign p1_ready  = !rst && state == IDLE && any && gnt == P_DBG;
    assign p0_rvalid = state == DONE && gport == P_CPU;
    assign p1_rvalid = state == DONE && gport == P_DBG;
    assign p0_rdata  = p0_rvalid ? rdata_q : '0;
    assign p1_rdata  = p1_rvalid ? rdata_q : '0;
    assign mem_we    = mem_we_q && !rst;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign busy      = state != IDLE;

    // mem_we_q is raised on the accepting edge so it is high for exactly the ACCESS cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gport     <= P_CPU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            rdata_q   <= '0;
            mem_we_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    state     <= ACCESS;
                    gport     <= gnt;
                    lat_we    <= gnt ? p1_we : p0_we;
                    lat_addr  <= gnt ? p1_addr : p0_addr;
                    lat_wdata <= gnt ? p1_wdata : p0_wdata;
                    mem_we_q  <= gnt ? p1_we : p0_we;
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    cnt      <= CW'(RD_LAT - 1);
                    rdata_q  <= lat_we ? '0 : mem_rdata;
                    state    <= (lat_we || RD_LAT == 1) ? DONE : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state   <= DONE;
                        rdata_q <= mem_rdata;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
